fft_output_serializer: RTL and testbench
========================================

Name: fft_output_serializer

Overview:
- Sits directly downstream of the 8-point butterfly network and consumes its parallel result bank.
- On each new FFT result (rising edge of fft_ready_flag), it snapshots all N complex outputs into a shadow bank.
- It then streams the snapshot out one complex sample per handshake over a valid/ready interface, in natural order with index and last markers.
- It counts frames it had to drop because a new result arrived while the previous one was still streaming.

Parameters:
- N, 8: number of complex points per frame; power of two, 2..16.
- W, 16: bit width of each real/imag component (two's complement, passed through unmodified).
- IW, 3: width of out_index; must equal log2(N).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- fft_ready_flag  input  1  level flag from the butterfly network; results are valid while high.
- in_real_flat  input  N*W  parallel real results; element k at [k*W +: W].
- in_imag_flat  input  N*W  parallel imag results; element k at [k*W +: W].
- out_valid  output  1  out_real/out_imag/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the current sample.
- out_real  output  W  real part of the current sample.
- out_imag  output  W  imag part of the current sample.
- out_index  output  IW  bin index of the current sample, 0..N-1.
- out_last  output  1  high with the sample at index N-1.
- busy  output  1  a frame is captured and not yet fully streamed.
- drop_pulse  output  1  one-cycle pulse when a frame is discarded.
- drop_count  output  8  frames discarded since reset; saturates at 255.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - out_valid=0, out_real=0, out_imag=0, out_index=0, out_last=0, busy=0, drop_pulse=0, drop_count=0.
  - The registered previous fft_ready_flag resets to 0, so a flag already high when reset releases counts as a new edge.
  - The shadow bank may be left uncleared.
- Edge detect: new_frame = fft_ready_flag & ~flag_q; flag_q is registered every cycle.
- State IDLE:
  - out_valid=0, busy=0.
  - On new_frame: capture both input buses into the shadow bank, set idx=0, move to STREAM.
  - Latency: out_valid rises the cycle after the cycle in which new_frame is sampled high.
- State STREAM:
  - out_valid=1, busy=1.
  - out_real/out_imag = shadow[idx]; out_index=idx; out_last=(idx==N-1).
  - Outputs are registered and must hold stable while out_valid & ~out_ready.
  - Handshake (out_valid & out_ready) with idx<N-1: idx increments and the next sample appears the next cycle. Full throughput is one sample per cycle with out_ready held high.
  - Handshake at idx==N-1 with no new_frame in that cycle: return to IDLE; out_valid=0 the next cycle.
- Simultaneous last handshake and new_frame:
  - The new frame is accepted and recaptured; idx=0 and the state stays STREAM, so there is no bubble.
- Overlap (new_frame in STREAM other than on the last-handshake cycle):
  - The new frame is discarded and the shadow bank is untouched.
  - drop_pulse=1 for exactly one cycle, the cycle after detection.
  - drop_count increments, saturating at 255.
- fft_ready_flag held high for many cycles is one frame only; it must fall and rise again for a new frame.
- Capture does not depend on out_ready.
- Reset asserted mid-stream: the stream is abandoned immediately. The next cycle shows out_valid=0 and idx=0, and no partial frame resumes.
- Data path is a pure pass-through with no scaling, rounding or sign extension.

Test Plan:
1. Reset, then a frame with real[k]=k+1, imag[k]=-(k+1), flag pulsed high 1 cycle, out_ready=1 -> out_valid high 8 consecutive cycles starting 1 cycle after the edge. Index 0..7, real 1..8, imag -1..-8, out_last only at index 7, busy falls after the last beat.
2. Same frame with out_ready toggling 1,0,0,1,... -> each sample held stable while ready=0, no sample skipped or repeated, exactly 8 handshakes.
3. Second flag edge at stream beat 3 with different data (real=0x7FFF) -> drop_pulse single cycle, drop_count=1, remaining beats 3..7 still carry the first frame's data.
4. Second edge on the same cycle as the index-7 handshake -> the next cycle shows out_valid=1, index 0 with the new data, drop_count unchanged.
5. fft_ready_flag held high 40 cycles -> exactly one 8-beat frame. Then 256 overlapping edges -> drop_count saturates at 255.
6. rst asserted at beat 4 with flag still high -> out_valid=0 the next cycle. After rst release, the still-high flag starts a fresh frame at index 0.

Source files
------------

// File: rtl/fft_output_serializer_if.sv
// Output stream bundle of fft_output_serializer: one complex sample per
// valid/ready handshake, tagged with its bin index and a last marker.
interface fft_output_serializer_if #(
    parameter int W  = 16,
    parameter int IW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_real;
    logic [W-1:0]  out_imag;
    logic [IW-1:0] out_index;
    logic          out_last;

    modport master (
        output out_valid, out_real, out_imag, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_output_serializer.sv
// Snapshots the parallel FFT result bank on each rising edge of
// fft_ready_flag and streams it out in natural bin order. Frames arriving
// while a stream is in progress are dropped and counted (saturating).
module fft_output_serializer #(
    parameter int N  = 8,
    parameter int W  = 16,
    parameter int IW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_ready_flag,
    input  logic [N*W-1:0]        in_real_flat,
    input  logic [N*W-1:0]        in_imag_flat,
    fft_output_serializer_if.master stream,
    output logic                  busy,
    output logic                  drop_pulse,
    output logic [7:0]            drop_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_n;
    logic          flag_q;
    logic [IW-1:0] idx_q, idx_n;
    logic          new_frame;
    logic          handshake;
    logic          at_last;
    logic          capture;
    logic          drop;
    logic [W-1:0]  shadow_re [N];
    logic [W-1:0]  shadow_im [N];
    logic [W-1:0]  real_n, imag_n;

    assign new_frame = fft_ready_flag & ~flag_q;
    assign handshake = stream.out_valid & stream.out_ready;
    assign at_last   = (idx_q == IW'(N - 1));
    assign busy      = (state_q == STREAM);

    // Previous flag level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) flag_q <= 1'b0;
        else     flag_q <= fft_ready_flag;
    end

    // FSM state and sample index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    // Next-state, index advance, capture and drop decisions.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_frame) begin
                    capture = 1'b1;
                    idx_n   = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (handshake && at_last) begin
                    // A frame landing on the final beat is taken without a bubble.
                    idx_n = '0;
                    if (new_frame) capture = 1'b1;
                    else           state_n = IDLE;
                end else begin
                    if (handshake) idx_n = idx_q + IW'(1);
                    drop = new_frame;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Shadow bank load; left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int unsigned k = 0; k < N; k++) begin
                shadow_re[k] <= in_real_flat[k*W +: W];
                shadow_im[k] <= in_imag_flat[k*W +: W];
            end
        end
    end

    // Next output sample: bypass the bank on the capture cycle since it is
    // only being written at the same edge.
    always_comb begin
        real_n = shadow_re[idx_n];
        imag_n = shadow_im[idx_n];
        if (capture) begin
            real_n = in_real_flat[W-1:0];
            imag_n = in_imag_flat[W-1:0];
        end
    end

    // Registered output stream; holds while stalled since idx and bank hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream.out_valid <= 1'b0;
            stream.out_real  <= '0;
            stream.out_imag  <= '0;
            stream.out_index <= '0;
            stream.out_last  <= 1'b0;
        end else begin
            stream.out_valid <= (state_n == STREAM);
            stream.out_real  <= real_n;
            stream.out_imag  <= imag_n;
            stream.out_index <= idx_n;
            stream.out_last  <= (state_n == STREAM) && (idx_n == IW'(N - 1));
        end
    end

    // Dropped-frame pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer: basic streaming, backpressure,
// overlap drops, back-to-back frames, held flag, saturation, mid-stream reset.
module tb_fft_output_serializer;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           flag;
    logic [N*W-1:0] in_re, in_im;
    logic           busy, drop_pulse;
    logic [7:0]     drop_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] a_re [N], a_im [N];
    logic [W-1:0] b_re [N], b_im [N];
    logic [W-1:0] c_re [N], c_im [N];

    fft_output_serializer_if #(.W(W), .IW(IW)) sif ();

    fft_output_serializer #(.N(N), .W(W), .IW(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fft_ready_flag (flag),
        .in_real_flat   (in_re),
        .in_imag_flat   (in_im),
        .stream         (sif),
        .busy           (busy),
        .drop_pulse     (drop_pulse),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task load(input int sel);
        for (int k = 0; k < N; k++) begin
            case (sel)
                0: begin in_re[k*W +: W] = a_re[k]; in_im[k*W +: W] = a_im[k]; end
                1: begin in_re[k*W +: W] = b_re[k]; in_im[k*W +: W] = b_im[k]; end
                default: begin in_re[k*W +: W] = c_re[k]; in_im[k*W +: W] = c_im[k]; end
            endcase
        end
    endtask

    task test_reset;
        rst = 1'b1; flag = 1'b0; sif.out_ready = 1'b0; in_re = '0; in_im = '0;
        tick; tick;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", sif.out_valid); end
        n_cmp++; if (sif.out_real !== 16'h0) begin n_err++; $display("FAIL reset_real got %h want 0000", sif.out_real); end
        n_cmp++; if (sif.out_imag !== 16'h0) begin n_err++; $display("FAIL reset_imag got %h want 0000", sif.out_imag); end
        n_cmp++; if (sif.out_index !== 3'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", sif.out_index); end
        n_cmp++; if (sif.out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", sif.out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL reset_drop_pulse got %b want 0", drop_pulse); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        rst = 1'b0;
        tick;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", sif.out_valid); end
    endtask

    task test_basic;
        load(0);
        sif.out_ready = 1'b1;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pre_valid got %b want 0", sif.out_valid); end
        flag = 1'b1;
        tick;
        flag = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (sif.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid beat %0d got %b want 1", k, sif.out_valid); end
            n_cmp++; if (sif.out_index !== IW'(k)) begin n_err++; $display("FAIL basic_index beat %0d got %0d want %0d", k, sif.out_index, k); end
            n_cmp++; if (sif.out_real !== a_re[k]) begin n_err++; $display("FAIL basic_real beat %0d got %h want %h", k, sif.out_real, a_re[k]); end
            n_cmp++; if (sif.out_imag !== a_im[k]) begin n_err++; $display("FAIL basic_imag beat %0d got %h want %h", k, sif.out_imag, a_im[k]); end
            n_cmp++; if (sif.out_last !== (k == N-1)) begin n_err++; $display("FAIL basic_last beat %0d got %b want %b", k, sif.out_last, k == N-1); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy beat %0d got %b want 1", k, busy); end
            tick;
        end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_end_valid got %b want 0", sif.out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy got %b want 0", busy); end
        n_cmp++; if (sif.out_last !== 1'b0) begin n_err++; $display("FAIL basic_end_last got %b want 0", sif.out_last); end
    endtask

    task test_backpressure;
        logic pat [4];
        int hs;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        load(0);
        sif.out_ready = 1'b0;
        flag = 1'b1;
        tick;
        flag = 1'b0;
        hs = 0;
        for (int c = 0; c < 40 && hs < N; c++) begin
            n_cmp++; if (sif.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cycle %0d got %b want 1", c, sif.out_valid); end
            n_cmp++; if (sif.out_index !== IW'(hs)) begin n_err++; $display("FAIL bp_index cycle %0d got %0d want %0d", c, sif.out_index, hs); end
            n_cmp++; if (sif.out_real !== a_re[hs]) begin n_err++; $display("FAIL bp_real cycle %0d got %h want %h", c, sif.out_real, a_re[hs]); end
            n_cmp++; if (sif.out_imag !== a_im[hs]) begin n_err++; $display("FAIL bp_imag cycle %0d got %h want %h", c, sif.out_imag, a_im[hs]); end
            sif.out_ready = pat[c % 4];
            if (sif.out_ready) hs++;
            tick;
        end
        n_cmp++; if (hs !== N) begin n_err++; $display("FAIL bp_handshakes got %0d want %0d", hs, N); end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid got %b want 0", sif.out_valid); end
        sif.out_ready = 1'b1;
    endtask

    task test_overlap_drop;
        load(0);
        sif.out_ready = 1'b1;
        flag = 1'b1;
        tick;
        flag = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (sif.out_index !== IW'(k)) begin n_err++; $display("FAIL ovl_index beat %0d got %0d want %0d", k, sif.out_index, k); end
            n_cmp++; if (sif.out_real !== a_re[k]) begin n_err++; $display("FAIL ovl_real beat %0d got %h want %h", k, sif.out_real, a_re[k]); end
            n_cmp++; if (sif.out_imag !== a_im[k]) begin n_err++; $display("FAIL ovl_imag beat %0d got %h want %h", k, sif.out_imag, a_im[k]); end
            n_cmp++; if (drop_pulse !== (k == 4)) begin n_err++; $display("FAIL ovl_drop_pulse beat %0d got %b want %b", k, drop_pulse, k == 4); end
            n_cmp++; if (drop_count !== ((k >= 4) ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL ovl_drop_count beat %0d got %0d want %0d", k, drop_count, (k >= 4) ? 1 : 0); end
            if (k == 3) begin load(1); flag = 1'b1; end
            if (k == 4) flag = 1'b0;
            tick;
        end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL ovl_end_valid got %b want 0", sif.out_valid); end
    endtask

    task test_back_to_back;
        load(0);
        flag = 1'b1;
        tick;
        flag = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (sif.out_real !== a_re[k]) begin n_err++; $display("FAIL b2b_first_real beat %0d got %h want %h", k, sif.out_real, a_re[k]); end
            if (k == N-1) begin load(2); flag = 1'b1; end
            tick;
        end
        flag = 1'b0;
        n_cmp++; if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL b2b_drop_pulse got %b want 0", drop_pulse); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL b2b_drop_count got %0d want 1", drop_count); end
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (sif.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid beat %0d got %b want 1", k, sif.out_valid); end
            n_cmp++; if (sif.out_index !== IW'(k)) begin n_err++; $display("FAIL b2b_index beat %0d got %0d want %0d", k, sif.out_index, k); end
            n_cmp++; if (sif.out_real !== c_re[k]) begin n_err++; $display("FAIL b2b_real beat %0d got %h want %h", k, sif.out_real, c_re[k]); end
            n_cmp++; if (sif.out_imag !== c_im[k]) begin n_err++; $display("FAIL b2b_imag beat %0d got %h want %h", k, sif.out_imag, c_im[k]); end
            tick;
        end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got %b want 0", sif.out_valid); end
    endtask

    task test_held_flag_and_saturation;
        int hs;
        load(0);
        sif.out_ready = 1'b1;
        flag = 1'b1;
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            if (sif.out_valid && sif.out_ready) hs++;
            tick;
        end
        n_cmp++; if (hs !== N) begin n_err++; $display("FAIL held_beats got %0d want %0d", hs, N); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL held_drop_count got %0d want 1", drop_count); end
        flag = 1'b0;
        tick;
        // Start a frame and stall it so every later edge overlaps.
        flag = 1'b1;
        tick;
        flag = 1'b0;
        sif.out_ready = 1'b0;
        tick;
        for (int i = 0; i < 256; i++) begin
            flag = 1'b1;
            tick;
            flag = 1'b0;
            tick;
            if (i == 252) begin
                n_cmp++; if (drop_count !== 8'd254) begin n_err++; $display("FAIL sat_pre_count got %0d want 254", drop_count); end
            end
        end
        n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_count got %0d want 255", drop_count); end
        n_cmp++; if (sif.out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid got %b want 1", sif.out_valid); end
        n_cmp++; if (sif.out_index !== 3'd0) begin n_err++; $display("FAIL sat_index got %0d want 0", sif.out_index); end
    endtask

    task test_reset_midstream;
        sif.out_ready = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 20 && sif.out_valid; c++) tick;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_drain_valid got %b want 0", sif.out_valid); end
        load(0);
        flag = 1'b1;
        tick;
        for (int k = 0; k < 4; k++) tick;
        n_cmp++; if (sif.out_index !== 3'd4) begin n_err++; $display("FAIL rst_pre_index got %0d want 4", sif.out_index); end
        rst = 1'b1;
        tick;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", sif.out_valid); end
        n_cmp++; if (sif.out_index !== 3'd0) begin n_err++; $display("FAIL rst_mid_index got %0d want 0", sif.out_index); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_mid_drop_count got %0d want 0", drop_count); end
        rst = 1'b0;
        tick;
        flag = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (sif.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_restart_valid beat %0d got %b want 1", k, sif.out_valid); end
            n_cmp++; if (sif.out_index !== IW'(k)) begin n_err++; $display("FAIL rst_restart_index beat %0d got %0d want %0d", k, sif.out_index, k); end
            n_cmp++; if (sif.out_real !== a_re[k]) begin n_err++; $display("FAIL rst_restart_real beat %0d got %h want %h", k, sif.out_real, a_re[k]); end
            tick;
        end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_restart_end got %b want 0", sif.out_valid); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            a_re[k] = 16'(k + 1);
            a_im[k] = 16'(-(k + 1));
            b_re[k] = 16'h7FFF;
            b_im[k] = 16'h8000;
            c_re[k] = 16'(16'h0100 + k);
            c_im[k] = 16'(16'hA000 + k);
        end
        test_reset;
        test_basic;
        test_backpressure;
        test_overlap_drop;
        test_back_to_back;
        test_held_flag_and_saturation;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
